// File: rtl/u409_pkg.sv
// Shared definitions for the U409 local-bus blocks: RTC sequencer state
// encoding and the CLK40 period.
`timescale 1ns/100ps
package u409_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_STROBE   = 3'd2;
    localparam logic [2:0] ST_HOLD     = 3'd3;
    localparam logic [2:0] ST_ACK      = 3'd4;
    localparam logic [2:0] ST_ACK_HOLD = 3'd5;
    localparam logic [2:0] ST_RECOVER  = 3'd6;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        SETUP    = ST_SETUP,
        STROBE   = ST_STROBE,
        HOLD     = ST_HOLD,
        ACK      = ST_ACK,
        ACK_HOLD = ST_ACK_HOLD,
        RECOVER  = ST_RECOVER
    } rtc_state_t;

    // 25 ns CLK40 period; default write access is 10 clocks = 250 ns.
    localparam int CLK40_PERIOD_NS = 25;

    // A timed state lasting n clocks starts its down-counter at n-1.
    function automatic logic [3:0] load_val(input int unsigned n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/rtc_cycle_ctrl.sv
// RTC bus-cycle sequencer: decodes an RTC access on the U409 local bus and
// generates CSn/RDn/WRn timing, buffer control and a single-clock TACK.
`timescale 1ns/100ps
module rtc_cycle_ctrl
    import u409_pkg::*;
#(
    parameter int unsigned SETUP_CLKS    = 2,
    parameter int unsigned STROBE_CLKS   = 6,
    parameter int unsigned HOLD_CLKS     = 2,
    parameter int unsigned ACK_HOLD_CLKS = 2,
    parameter int unsigned RECOVER_CLKS  = 4
) (
    input  logic CLK40,
    input  logic RESETn,
    input  logic TSn,
    input  logic RnW,
    input  logic RTC_SPACE,
    output logic RTC_CSn,
    output logic RTC_RDn,
    output logic RTC_WRn,
    output logic RTC_DBUF_OEn,
    output logic RTC_DIR,
    output logic RTC_TACK,
    output logic RTC_BUSY
);

    rtc_state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       rd, rd_nxt;
    logic       start;

    logic csn_nxt, rdn_nxt, wrn_nxt, oen_nxt, dir_nxt, tack_nxt, busy_nxt;

    assign start = !TSn && RTC_SPACE;

    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rd    <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rd    <= rd_nxt;
        end
    end

    // Each timed state counts down to zero, then loads the next state's count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_nxt    = rd;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETUP;
                    cnt_nxt   = load_val(SETUP_CLKS);
                    rd_nxt    = RnW;
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = load_val(STROBE_CLKS);
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    if (rd) begin
                        state_nxt = ACK;
                        cnt_nxt   = 4'd0;
                    end else begin
                        state_nxt = HOLD;
                        cnt_nxt   = load_val(HOLD_CLKS);
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    state_nxt = ACK;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ACK: begin
                if (rd) begin
                    state_nxt = ACK_HOLD;
                    cnt_nxt   = load_val(ACK_HOLD_CLKS);
                end else begin
                    state_nxt = RECOVER;
                    cnt_nxt   = load_val(RECOVER_CLKS);
                end
            end
            ACK_HOLD: begin
                if (cnt == 4'd0) begin
                    state_nxt = RECOVER;
                    cnt_nxt   = load_val(RECOVER_CLKS);
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RECOVER: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they can be registered
    // without an extra clock of latency.
    always_comb begin
        csn_nxt  = 1'b1;
        rdn_nxt  = 1'b1;
        wrn_nxt  = 1'b1;
        oen_nxt  = 1'b1;
        dir_nxt  = 1'b1;
        tack_nxt = 1'b0;
        busy_nxt = 1'b1;
        case (state_nxt)
            IDLE: begin
                busy_nxt = 1'b0;
            end
            SETUP, HOLD: begin
                csn_nxt = 1'b0;
                oen_nxt = 1'b0;
                dir_nxt = rd_nxt;
            end
            STROBE: begin
                csn_nxt = 1'b0;
                oen_nxt = 1'b0;
                dir_nxt = rd_nxt;
                rdn_nxt = !rd_nxt;
                wrn_nxt = rd_nxt;
            end
            ACK: begin
                tack_nxt = 1'b1;
                dir_nxt  = rd_nxt;
                if (rd_nxt) begin
                    csn_nxt = 1'b0;
                    oen_nxt = 1'b0;
                    rdn_nxt = 1'b0;
                end
            end
            ACK_HOLD: begin
                csn_nxt = 1'b0;
                oen_nxt = 1'b0;
                rdn_nxt = 1'b0;
                dir_nxt = rd_nxt;
            end
            RECOVER: begin
                busy_nxt = 1'b1;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            RTC_CSn      <= 1'b1;
            RTC_RDn      <= 1'b1;
            RTC_WRn      <= 1'b1;
            RTC_DBUF_OEn <= 1'b1;
            RTC_DIR      <= 1'b1;
            RTC_TACK     <= 1'b0;
            RTC_BUSY     <= 1'b0;
        end else begin
            RTC_CSn      <= csn_nxt;
            RTC_RDn      <= rdn_nxt;
            RTC_WRn      <= wrn_nxt;
            RTC_DBUF_OEn <= oen_nxt;
            RTC_DIR      <= dir_nxt;
            RTC_TACK     <= tack_nxt;
            RTC_BUSY     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rtc_cycle_ctrl.sv
// Directed bench for rtc_cycle_ctrl: default-timing and minimum-timing
// instances driven from per-cycle vector tables plus a mid-cycle reset.
`timescale 1ns/100ps
module tb_rtc_cycle_ctrl;
    import u409_pkg::*;

    // Output vector order: {CSn, RDn, WRn, DBUF_OEn, DIR, TACK, BUSY}
    localparam logic [6:0] O_IDLE   = 7'b1111100;
    localparam logic [6:0] W_SETUP  = 7'b0110001;
    localparam logic [6:0] W_STROBE = 7'b0100001;
    localparam logic [6:0] W_HOLD   = 7'b0110001;
    localparam logic [6:0] W_ACK    = 7'b1111011;
    localparam logic [6:0] RECOV    = 7'b1111101;
    localparam logic [6:0] R_SETUP  = 7'b0110101;
    localparam logic [6:0] R_STROBE = 7'b0010101;
    localparam logic [6:0] R_ACK    = 7'b0010111;
    localparam logic [6:0] R_AHOLD  = 7'b0010101;

    typedef struct {
        logic       tsn;
        logic       space;
        logic       rnw;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    logic CLK40  = 1'b0;
    logic RESETn = 1'b0;
    logic tsn_a = 1'b1, rnw_a = 1'b1, space_a = 1'b0;
    logic tsn_b = 1'b1, rnw_b = 1'b1, space_b = 1'b0;

    logic csn_a, rdn_a, wrn_a, oen_a, dir_a, tack_a, busy_a;
    logic csn_b, rdn_b, wrn_b, oen_b, dir_b, tack_b, busy_b;
    logic [6:0] out_a, out_b;

    assign out_a = {csn_a, rdn_a, wrn_a, oen_a, dir_a, tack_a, busy_a};
    assign out_b = {csn_b, rdn_b, wrn_b, oen_b, dir_b, tack_b, busy_b};

    always #(CLK40_PERIOD_NS / 2.0) CLK40 = ~CLK40;

    rtc_cycle_ctrl dut_a (
        .CLK40(CLK40), .RESETn(RESETn), .TSn(tsn_a), .RnW(rnw_a),
        .RTC_SPACE(space_a), .RTC_CSn(csn_a), .RTC_RDn(rdn_a),
        .RTC_WRn(wrn_a), .RTC_DBUF_OEn(oen_a), .RTC_DIR(dir_a),
        .RTC_TACK(tack_a), .RTC_BUSY(busy_a)
    );

    rtc_cycle_ctrl #(
        .SETUP_CLKS(1), .STROBE_CLKS(1), .HOLD_CLKS(1), .RECOVER_CLKS(1)
    ) dut_b (
        .CLK40(CLK40), .RESETn(RESETn), .TSn(tsn_b), .RnW(rnw_b),
        .RTC_SPACE(space_b), .RTC_CSn(csn_b), .RTC_RDn(rdn_b),
        .RTC_WRn(wrn_b), .RTC_DBUF_OEn(oen_b), .RTC_DIR(dir_b),
        .RTC_TACK(tack_b), .RTC_BUSY(busy_b)
    );

    task automatic checkOutput(input string name, input logic [6:0] got,
                               input logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %b required %b (CSn RDn WRn OEn DIR TACK BUSY)",
                     name, got, want);
        end
    endtask

    task automatic addRows(input logic tsn, input logic space, input logic rnw,
                           input logic [6:0] exp, input int n);
        vec_t v;
        v.tsn = tsn; v.space = space; v.rnw = rnw; v.exp = exp;
        repeat (n) vecs.push_back(v);
    endtask

    // One row per clock: inputs seen by the next posedge, outputs after it.
    task automatic applyStimulus(input bit use_b, input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            if (use_b) begin
                tsn_b = vecs[i].tsn; space_b = vecs[i].space; rnw_b = vecs[i].rnw;
            end else begin
                tsn_a = vecs[i].tsn; space_a = vecs[i].space; rnw_a = vecs[i].rnw;
            end
            @(negedge CLK40);
            checkOutput($sformatf("%s_row%0d", tag, i), use_b ? out_b : out_a,
                        vecs[i].exp);
        end
        tsn_a = 1'b1; space_a = 1'b0;
        tsn_b = 1'b1; space_b = 1'b0;
        vecs.delete();
    endtask

    task automatic addWriteDefault();
        addRows(1'b0, 1'b1, 1'b0, W_SETUP, 1);
        addRows(1'b1, 1'b0, 1'b0, W_SETUP, 1);
        addRows(1'b1, 1'b0, 1'b0, W_STROBE, 6);
        addRows(1'b1, 1'b0, 1'b0, W_HOLD, 2);
        addRows(1'b1, 1'b0, 1'b0, W_ACK, 1);
        addRows(1'b1, 1'b0, 1'b0, RECOV, 4);
        addRows(1'b1, 1'b0, 1'b0, O_IDLE, 1);
    endtask

    initial begin
        repeat (2) @(negedge CLK40);
        checkOutput("reset_a", out_a, O_IDLE);
        checkOutput("reset_b", out_b, O_IDLE);
        RESETn = 1'b1;
        @(negedge CLK40);

        // Default timing: decode miss, write, read with stray TSn in RECOVER,
        // then a write accepted on the first IDLE edge.
        addRows(1'b0, 1'b0, 1'b0, O_IDLE, 3);
        addRows(1'b1, 1'b1, 1'b0, O_IDLE, 1);
        addWriteDefault();
        addRows(1'b0, 1'b1, 1'b1, R_SETUP, 1);
        addRows(1'b1, 1'b0, 1'b1, R_SETUP, 1);
        addRows(1'b1, 1'b0, 1'b1, R_STROBE, 6);
        addRows(1'b1, 1'b0, 1'b1, R_ACK, 1);
        addRows(1'b1, 1'b0, 1'b1, R_AHOLD, 2);
        addRows(1'b1, 1'b0, 1'b1, RECOV, 1);
        addRows(1'b0, 1'b1, 1'b0, RECOV, 1);
        addRows(1'b1, 1'b0, 1'b1, RECOV, 2);
        addRows(1'b0, 1'b1, 1'b0, O_IDLE, 1);
        addWriteDefault();
        addRows(1'b1, 1'b0, 1'b0, O_IDLE, 2);
        applyStimulus(1'b0, "dflt");

        // Minimum timing instance: write then read.
        addRows(1'b0, 1'b1, 1'b0, W_SETUP, 1);
        addRows(1'b1, 1'b0, 1'b0, W_STROBE, 1);
        addRows(1'b1, 1'b0, 1'b0, W_HOLD, 1);
        addRows(1'b1, 1'b0, 1'b0, W_ACK, 1);
        addRows(1'b1, 1'b0, 1'b0, RECOV, 1);
        addRows(1'b1, 1'b0, 1'b0, O_IDLE, 1);
        addRows(1'b0, 1'b1, 1'b1, R_SETUP, 1);
        addRows(1'b1, 1'b0, 1'b1, R_STROBE, 1);
        addRows(1'b1, 1'b0, 1'b1, R_ACK, 1);
        addRows(1'b1, 1'b0, 1'b1, R_AHOLD, 2);
        addRows(1'b1, 1'b0, 1'b1, RECOV, 1);
        addRows(1'b1, 1'b0, 1'b1, O_IDLE, 2);
        applyStimulus(1'b1, "min");

        // Reset in the middle of a write strobe must release lines at once.
        tsn_a = 1'b0; space_a = 1'b1; rnw_a = 1'b0;
        @(negedge CLK40);
        tsn_a = 1'b1; space_a = 1'b0;
        repeat (4) @(negedge CLK40);
        checkOutput("pre_reset_strobe", out_a, W_STROBE);
        RESETn = 1'b0;
        #1;
        checkOutput("async_reset_release", out_a, O_IDLE);
        @(negedge CLK40);
        checkOutput("held_in_reset", out_a, O_IDLE);
        RESETn = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK40);
            checkOutput($sformatf("post_reset_idle%0d", i), out_a, O_IDLE);
        end

        addWriteDefault();
        applyStimulus(1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_cycle_ctrl.md
Name: rtc_cycle_ctrl

Overview:
- Real-time-clock bus-cycle sequencer for the 4-bit RTC on the U409 local bus.
- Decodes an RTC cycle from the CPU (TSn plus RTC_SPACE) and drives RTC_CSn, RTC_RDn and RTC_WRn with programmable setup, strobe and hold timing.
- Produces the single-clock RTC_TACK pulse consumed by the transfer-ack block, which terminates the CPU cycle.
- Enforces a recovery gap between back-to-back RTC accesses.

Parameters:
- SETUP_CLKS, 2, CLK40 cycles from CSn low to strobe low; legal range 1..15.
- STROBE_CLKS, 6, CLK40 cycles the RDn/WRn strobe is low before ack or hold; legal range 1..15.
- HOLD_CLKS, 2, write only: cycles CSn and data stay valid after WRn rises; legal range 1..15.
- ACK_HOLD_CLKS, 2, read only: cycles RDn stays low after the RTC_TACK pulse, so data stays valid until the CPU samples; legal range 1..15.
- RECOVER_CLKS, 4, idle cycles after release before a new cycle is accepted; legal range 1..15.

Ports:
- CLK40  in  1  40 MHz system clock.
- RESETn  in  1  Asynchronous, active-low reset.
- TSn  in  1  CPU transfer start, active low, sampled on posedge CLK40.
- RnW  in  1  1 = read, 0 = write; latched at cycle start.
- RTC_SPACE  in  1  Address decode hit for the RTC.
- RTC_CSn  out  1  RTC chip select.
- RTC_RDn  out  1  RTC read strobe.
- RTC_WRn  out  1  RTC write strobe.
- RTC_DBUF_OEn  out  1  Data buffer enable.
- RTC_DIR  out  1  Buffer direction; 1 = RTC to CPU.
- RTC_TACK  out  1  One-clock ack request to the transfer-ack block.
- RTC_BUSY  out  1  High in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset values: CSn = RDn = WRn = DBUF_OEn = 1; DIR = 1; TACK = 0; BUSY = 0; state = IDLE; counter = 0.
- Reset asserted mid-cycle releases every strobe immediately (asynchronous) and returns to IDLE.
- States: IDLE, SETUP, STROBE, HOLD, ACK, ACK_HOLD, RECOVER. A single 4-bit down-counter is loaded with N-1 on entry to each timed state; the state exits when the counter reaches 0.
- Edge E0 is the first posedge with TSn = 0 and RTC_SPACE = 1 in IDLE.
- IDLE -> SETUP at E0: CSn = 0, DBUF_OEn = 0, DIR = RnW, and RnW is latched as rd.
- SETUP -> STROBE after SETUP_CLKS edges: RDn = 0 if rd, otherwise WRn = 0.
- STROBE, write path: after STROBE_CLKS go to HOLD with WRn = 1. After HOLD_CLKS go to ACK with CSn = 1, DBUF_OEn = 1 and TACK = 1.
- STROBE, read path: after STROBE_CLKS go to ACK with TACK = 1; RDn, CSn and DBUF_OEn stay low. ACK then goes to ACK_HOLD with TACK = 0. After ACK_HOLD_CLKS go to RECOVER with RDn = CSn = DBUF_OEn = 1.
- Write path: ACK lasts exactly 1 clock (TACK = 0 on exit), then goes to RECOVER.
- RECOVER: DIR returns to 1. After RECOVER_CLKS go to IDLE.
- Write latency E0 to TACK high = SETUP + STROBE + HOLD clocks; defaults give 10 clocks (250 ns).
- Read latency = SETUP + STROBE clocks; defaults give 8 clocks.
- RTC_TACK is high for exactly one CLK40 cycle per access and never otherwise.
- TSn and RTC_SPACE are ignored outside IDLE, including a new TSn that arrives during RECOVER.
- Simultaneous TSn with RTC_SPACE = 0: stay in IDLE.
- RDn and WRn are never low at the same time. Each strobe is low only while CSn is low.

Decomposition:
- Shared package u409_pkg holds:
  - the state encoding localparams (3-bit);
  - the CLK40 period constant (25 ns) used in timing comments and the bench.
- No sub-module is required; the state machine and counter live in one module.

Test Plan:
- Reset, then a write with default parameters: TSn low 1 clock, RnW = 0, RTC_SPACE = 1. Required response:
  - CSn low at E0+1;
  - WRn low from E0+3 to E0+8;
  - TACK high only at E0+11;
  - BUSY low again at E0+16.
- Read with default parameters: required response is TACK high at E0+9, RDn low from E0+3 through E0+11, DIR = 1 throughout, and CSn high at E0+12.
- Second TSn with RTC_SPACE = 1 during RECOVER: ignored, no second TACK. A TSn issued after BUSY falls starts a new cycle.
- RESETn pulsed low during STROBE of a write: WRn and CSn go high without waiting for a clock edge, no TACK pulse, and the block returns to IDLE.
- TSn low with RTC_SPACE = 0: all outputs hold their reset values.
- Parameters SETUP = STROBE = HOLD = RECOVER = 1: write TACK at E0+4, and the minimum boundary timing is respected.
